// File: rtl/pipe_skid_reg_pkg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg_pkg
// Shared definitions for the elastic pipeline stage register.
//   skid_state_e : occupancy of the stage (EMPTY / ONE / TWO words held)
//   STALL_CNT_W  : width of the optional stall statistics counter
// -----------------------------------------------------------------------------
package pipe_skid_reg_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // no words held
        ONE   = 2'd1,   // main entry valid
        TWO   = 2'd2    // main and skid entries valid
    } skid_state_e;

    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/pipe_skid_reg_stat_cnt.sv
// -----------------------------------------------------------------------------
// pipe_stat_cnt
// Saturating event counter used for the stage stall statistics.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (clears the count)
//   inc_i  : count one event this cycle
//   cnt_o  : current count, sticks at all-ones
// -----------------------------------------------------------------------------
module pipe_stat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
// Elastic pipeline stage register with a skid entry. Accepts a word under a
// valid/ready handshake and presents it downstream one cycle later. Every
// output is a register, so no combinational path runs from out_ready to
// in_ready.
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   flush      : discard all held words; wins over every other input
//   in_valid   : upstream word present
//   in_data    : upstream payload [WIDTH-1:0]
//   in_ready   : stage accepts a word this cycle (registered)
//   out_valid  : out_data valid (registered)
//   out_data   : payload to downstream, always the main entry (registered)
//   stall_cnt  : cycles with out_valid & ~out_ready, saturating
//                (only when PIPE_SKID_STATS_EN is defined)
//   out_ready  : downstream accepts this cycle
// Build option: define PIPE_SKID_STATS_EN to add the stall_cnt port/counter.
// -----------------------------------------------------------------------------
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
`ifdef PIPE_SKID_STATS_EN
    output logic [STALL_CNT_W-1:0] stall_cnt,
`endif
    input  logic                   out_ready
);

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic up_xfer;
    logic dn_xfer;

    assign up_xfer = in_valid & in_ready_q;
    assign dn_xfer = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            // Offered word is dropped; a downstream transfer this cycle
            // still completes since main simply stops being presented.
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (up_xfer) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (up_xfer && dn_xfer) begin
                        main_d = in_data;
                    end else if (up_xfer) begin
                        state_d = TWO;
                        skid_d  = in_data;
                    end else if (dn_xfer) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only the drain can happen.
                    if (dn_xfer) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end

        // Handshake flags are registered copies of the next occupancy.
        in_ready_d  = (state_d != TWO);
        out_valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

`ifdef PIPE_SKID_STATS_EN
    // Flush does not reach the counter; only reset clears it.
    pipe_stat_cnt #(
        .W (STALL_CNT_W)
    ) u_stat_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (out_valid_q & ~out_ready),
        .cnt_o (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_reg
// Self-checking bench for pipe_skid_reg: table-driven per-cycle vectors,
// hand-written reset/flush/backpressure sequences, and a scoreboard queue
// that tracks the words held in the stage and checks the outputs each cycle.
// Define PIPE_SKID_STATS_EN to also exercise the stall counter.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipe_skid_reg;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
`ifdef PIPE_SKID_STATS_EN
    logic [15:0] stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    pipe_skid_reg #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
`ifdef PIPE_SKID_STATS_EN
        .stall_cnt (stall_cnt),
`endif
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Advance one clock; return 1 ns after the edge (inputs driven, outputs sampled here).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: words currently held by the stage, oldest first. Predicted
    // transfers are taken from the model's own occupancy, not from the DUT.
    logic [31:0] sb_q[$];

    always @(negedge clk) begin
        int n;
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            n = sb_q.size();
            check("sb_out_valid", {31'd0, out_valid}, {31'd0, n != 0});
            check("sb_in_ready", {31'd0, in_ready}, {31'd0, n < 2});
            if (n != 0) check("sb_out_data", out_data, sb_q[0]);
            if (n != 0 && out_ready) begin
                $display("tb: out word %h", sb_q[0]);
                void'(sb_q.pop_front());
            end
            if (flush) sb_q.delete();
            else if (in_valid && n < 2) sb_q.push_back(in_data);
        end
    end

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        fl;
        logic        ov;
        logic [31:0] od;
        logic        ir;
    } vec_t;

    vec_t tbl[21];

    initial begin
        // {in_valid, in_data, out_ready, flush, exp out_valid, exp out_data, exp in_ready}
        for (int i = 0; i < 8; i++)
            tbl[i] = '{1'b1, 32'(i + 1), 1'b1, 1'b0, 1'b1, 32'(i + 1), 1'b1};
        tbl[8]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h8,  1'b1};
        // backpressure: one more accept after out_ready falls, then in_ready drops
        tbl[9]  = '{1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 32'h10, 1'b1};
        tbl[10] = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0};
        tbl[11] = '{1'b1, 32'h12, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0};
        tbl[12] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h11, 1'b1};
        tbl[13] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h11, 1'b1};
        // flush in TWO while offering 0x20
        tbl[14] = '{1'b1, 32'h1F, 1'b0, 1'b0, 1'b1, 32'h1F, 1'b1};
        tbl[15] = '{1'b1, 32'h21, 1'b0, 1'b0, 1'b1, 32'h1F, 1'b0};
        tbl[16] = '{1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 32'h1F, 1'b1};
        tbl[17] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h1F, 1'b1};
        // flush with in_ready=1 and a downstream transfer in the same cycle
        tbl[18] = '{1'b1, 32'h30, 1'b1, 1'b0, 1'b1, 32'h30, 1'b1};
        tbl[19] = '{1'b1, 32'h31, 1'b1, 1'b1, 1'b0, 32'h30, 1'b1};
        tbl[20] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h30, 1'b1};

        // Reset with in_valid already high
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA5A5_0001;
        out_ready = 1'b1;
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'h0);
`ifdef PIPE_SKID_STATS_EN
        check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("first_out_valid", {31'd0, out_valid}, 32'd1);
        check("first_out_data", out_data, 32'hA5A5_0001);
        in_valid = 1'b0;
        tick();
        check("drain_out_valid", {31'd0, out_valid}, 32'd0);
        check("hold_out_data", out_data, 32'hA5A5_0001);

        for (int i = 0; i < 21; i++) begin
            in_valid  = tbl[i].iv;
            in_data   = tbl[i].d;
            out_ready = tbl[i].ordy;
            flush     = tbl[i].fl;
            tick();
            $display("tb: vec%0d iv=%0b d=%h ordy=%0b fl=%0b -> ov=%0b od=%h ir=%0b",
                     i, tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl, out_valid, out_data, in_ready);
            check($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ov});
            check($sformatf("vec%0d_out_data", i), out_data, tbl[i].od);
            check($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].ir});
        end
        flush = 1'b0;

        // Async reset while in TWO
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h60;
        tick();
        in_data   = 32'h61;
        tick();
        in_valid  = 1'b0;
        check("two_in_ready", {31'd0, in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_out_data", out_data, 32'h0);
`ifdef PIPE_SKID_STATS_EN
        check("arst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h40;
        out_ready = 1'b1;
        tick();
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd1);
        check("post_rst_out_data", out_data, 32'h40);
        in_valid = 1'b0;
        tick();

`ifdef PIPE_SKID_STATS_EN
        // Hold a word with out_ready low long enough to saturate the counter
        in_valid  = 1'b1;
        in_data   = 32'h50;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        for (int c = 0; c < 70000; c++) @(posedge clk);
        #1;
        check("stall_sat", {16'd0, stall_cnt}, 32'h0000_FFFF);
        for (int c = 0; c < 10; c++) @(posedge clk);
        #1;
        check("stall_stays", {16'd0, stall_cnt}, 32'h0000_FFFF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("stall_no_flush_clr", {16'd0, stall_cnt}, 32'h0000_FFFF);
        out_ready = 1'b1;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
